// File: rtl/exu_div.sv
// exu_div: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Special cases finish on the accept cycle; normal ops take 32 CALC cycles.
package exu_div_pkg;
    typedef enum logic [2:0] {DIV_NONE, DIV_DIV, DIV_DIVU, DIV_REM, DIV_REMU} riscv_div_op_e;
    typedef struct packed {
        logic [31:0]   dataA;
        logic [31:0]   dataB;
        riscv_div_op_e opcode;
    } alu_div_t;
endpackage

module exu_div
    import exu_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  alu_div_t    in_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e      state;
    logic [4:0]  cnt;
    logic [31:0] remR, quo, divisor;
    logic        isRem, negQ, negR;
    logic        isSigned, isRemOp, aNeg, bNeg, divZero, ovf, special;
    logic [31:0] magA, magB, specialRes;
    logic [32:0] remShift, sub;
    logic        geq;
    logic [31:0] remNext, quoNext, finalRes;

    always_comb begin
        isSigned   = in_data.opcode == DIV_DIV || in_data.opcode == DIV_REM;
        isRemOp    = in_data.opcode == DIV_REM || in_data.opcode == DIV_REMU;
        aNeg       = isSigned & in_data.dataA[31];
        bNeg       = isSigned & in_data.dataB[31];
        magA       = aNeg ? -in_data.dataA : in_data.dataA;
        magB       = bNeg ? -in_data.dataB : in_data.dataB;
        divZero    = in_data.dataB == 32'd0;
        ovf        = isSigned && in_data.dataA == 32'h8000_0000 && in_data.dataB == 32'hFFFF_FFFF;
        special    = in_data.opcode == DIV_NONE || divZero || ovf;
        specialRes = in_data.opcode == DIV_NONE ? 32'd0 :
                     divZero ? (isRemOp ? in_data.dataA : 32'hFFFF_FFFF) :
                     (isRemOp ? 32'd0 : 32'h8000_0000);
        // remShift < 2*divisor always, so the borrow bit alone decides rem >= divisor
        remShift   = {remR, quo[31]};
        sub        = remShift - {1'b0, divisor};
        geq        = ~sub[32];
        remNext    = geq ? sub[31:0] : remShift[31:0];
        quoNext    = {quo[30:0], geq};
        finalRes   = isRem ? (negR ? -remNext : remNext) : (negQ ? -quoNext : quoNext);
    end

    assign in_ready = state == IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            out_result <= 32'd0;
            cnt        <= 5'd0;
            remR       <= 32'd0;
            quo        <= 32'd0;
            divisor    <= 32'd0;
            isRem      <= 1'b0;
            negQ       <= 1'b0;
            negR       <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            cnt       <= 5'd0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    isRem   <= isRemOp;
                    negQ    <= aNeg ^ bNeg;
                    negR    <= aNeg;
                    divisor <= magB;
                    quo     <= magA;
                    remR    <= 32'd0;
                    cnt     <= 5'd0;
                    if (special) begin
                        state      <= DONE;
                        out_valid  <= 1'b1;
                        out_result <= specialRes;
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    remR <= remNext;
                    quo  <= quoNext;
                    cnt  <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state      <= DONE;
                        out_valid  <= 1'b1;
                        out_result <= finalRes;
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
